uart_cmd_parser: RTL and testbench

UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

---
 rtl/uart_cmd_pkg.sv | 36 +++
 rtl/cmd_timer.sv | 38 +++
 rtl/uart_cmd_parser.sv | 209 ++++++++++++++++++++
 tb/tb_uart_cmd_parser.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// ============================================================================
//  Module   : uart_cmd_pkg
//  Purpose  : Frame constants, FSM state encoding and checksum helper shared
//             by the UART command parser and its sub-blocks.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

    localparam logic [7:0] SYNC     = 8'hA5;
    localparam logic [7:0] ACK      = 8'h06;
    localparam logic [7:0] NAK      = 8'h15;
    localparam logic [7:0] OP_APPLY = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_OPC    = 4'd1,
        ST_OPD    = 4'd2,
        ST_CHK    = 4'd3,
        ST_SETTLE = 4'd4,
        ST_SEND0  = 4'd5,
        ST_WAIT0  = 4'd6,
        ST_SEND1  = 4'd7,
        ST_WAIT1  = 4'd8
    } state_t;

    function automatic logic [7:0] frame_check(input logic [7:0] opcode,
                                               input logic [7:0] operand);
        return opcode ^ operand;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cmd_timer.sv
// ============================================================================
//  Module   : cmd_timer
//  Purpose  : Loadable down-counter; expired is high once the loaded number
//             of cycles has elapsed and stays high until the next load.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module cmd_timer #(
    parameter int WIDTH = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] count;

    // Loading N makes expired rise in the N-th cycle after the load edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_value - ONE;
        end else if (count != '0) begin
            count <= count - ONE;
        end
    end

    assign expired = (count == '0);

endmodule

`default_nettype wire

// File: rtl/uart_cmd_parser.sv
// ============================================================================
//  Module   : uart_cmd_parser
//  Purpose  : Parses A5/opcode/operand/check frames from a UART byte stream,
//             drives or samples a gate vector and replies with two bytes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 100,
    parameter int TIMEOUT_CYCLES = 416_640
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_DONE,
    input  logic [7:0] RX_BUFFER,
    input  logic       TX_DONE,
    input  logic [7:0] GATE_OUT,
    output logic       RX_TRIGGER,
    output logic       TX_TRIGGER,
    output logic [7:0] TX_BUFFER,
    output logic [7:0] GATE_IN,
    output logic       BUSY,
    output logic [7:0] ERR_COUNT
);

    localparam int TIMER_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES
                                                                 : SETTLE_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX + 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD = TIMER_W'(TIMEOUT_CYCLES);
    localparam logic [TIMER_W-1:0] SETTLE_LOAD  = TIMER_W'(SETTLE_CYCLES);

    state_t state;
    state_t state_next;

    logic [7:0]         opcode;
    logic [7:0]         operand;
    logic [7:0]         chk_byte;
    logic [7:0]         reply_data;
    logic               frame_done;
    logic               rx_en;

    logic               byte_accept;
    logic               reply_nak;
    logic               cmd_apply;
    logic               cmd_read;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               timer_expired;

    cmd_timer #(
        .WIDTH(TIMER_W)
    ) u_cmd_timer (
        .clk       (CLK),
        .rst       (RST),
        .load      (timer_load),
        .load_value(timer_value),
        .expired   (timer_expired)
    );

    always_comb begin
        reply_nak = (frame_check(opcode, operand) != chk_byte) ||
                    !((opcode == OP_APPLY) || (opcode == OP_READ));
        cmd_apply = !reply_nak && (opcode == OP_APPLY);
        cmd_read  = !reply_nak && (opcode == OP_READ);
    end

    // frame_done marks the evaluation cycle that follows the check byte.
    always_comb begin
        byte_accept = 1'b0;
        case (state)
            ST_IDLE: byte_accept = RX_DONE && (RX_BUFFER == SYNC);
            ST_OPC,
            ST_OPD:  byte_accept = RX_DONE;
            ST_CHK:  byte_accept = RX_DONE && !frame_done;
            default: byte_accept = 1'b0;
        endcase
        timer_load  = byte_accept || ((state == ST_CHK) && frame_done && cmd_apply);
        timer_value = byte_accept ? TIMEOUT_LOAD : SETTLE_LOAD;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (byte_accept) begin
                    state_next = ST_OPC;
                end
            end
            ST_OPC: begin
                if (RX_DONE) begin
                    state_next = ST_OPD;
                end else if (timer_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_OPD: begin
                if (RX_DONE) begin
                    state_next = ST_CHK;
                end else if (timer_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_CHK: begin
                if (frame_done) begin
                    state_next = cmd_apply ? ST_SETTLE : ST_SEND0;
                end else if (!RX_DONE && timer_expired) begin
                    state_next = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (timer_expired) begin
                    state_next = ST_SEND0;
                end
            end
            ST_SEND0: state_next = ST_WAIT0;
            ST_WAIT0: begin
                if (TX_DONE) begin
                    state_next = ST_SEND1;
                end
            end
            ST_SEND1: state_next = ST_WAIT1;
            ST_WAIT1: begin
                if (TX_DONE) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        TX_TRIGGER = (state == ST_SEND0) || (state == ST_SEND1);
        BUSY       = (state != ST_IDLE);
        RX_TRIGGER = rx_en;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            opcode     <= 8'h00;
            operand    <= 8'h00;
            chk_byte   <= 8'h00;
            reply_data <= 8'h00;
            frame_done <= 1'b0;
            rx_en      <= 1'b0;
            TX_BUFFER  <= 8'h00;
            GATE_IN    <= 8'h00;
            ERR_COUNT  <= 8'h00;
        end else begin
            rx_en      <= 1'b1;
            frame_done <= (state == ST_CHK) && !frame_done && RX_DONE;
            case (state)
                ST_OPC: begin
                    if (RX_DONE) begin
                        opcode <= RX_BUFFER;
                    end
                end
                ST_OPD: begin
                    if (RX_DONE) begin
                        operand <= RX_BUFFER;
                    end
                end
                ST_CHK: begin
                    if (!frame_done) begin
                        if (RX_DONE) begin
                            chk_byte <= RX_BUFFER;
                        end
                    end else if (reply_nak) begin
                        TX_BUFFER  <= NAK;
                        reply_data <= opcode;
                        if (ERR_COUNT != 8'hFF) begin
                            ERR_COUNT <= ERR_COUNT + 8'd1;
                        end
                    end else if (cmd_read) begin
                        TX_BUFFER  <= ACK;
                        reply_data <= GATE_OUT;
                    end else begin
                        GATE_IN <= operand;
                    end
                end
                ST_SETTLE: begin
                    if (timer_expired) begin
                        TX_BUFFER  <= ACK;
                        reply_data <= GATE_OUT;
                    end
                end
                ST_WAIT0: begin
                    if (TX_DONE) begin
                        TX_BUFFER <= reply_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_parser.sv
// ============================================================================
//  Module   : tb_uart_cmd_parser
//  Purpose  : Randomized self-checking bench for uart_cmd_parser.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_cmd_parser;

    localparam int S = 5;
    localparam int T = 40;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       rx_done   = 1'b0;
    logic [7:0] rx_buffer = 8'h00;
    logic       tx_done   = 1'b0;
    logic [7:0] gate_out;
    logic       rx_trigger;
    logic       tx_trigger;
    logic [7:0] tx_buffer;
    logic [7:0] gate_in;
    logic       busy;
    logic [7:0] err_count;

    logic       gate_mode  = 1'b0;
    logic [7:0] gate_fixed = 8'h00;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_rx_cyc = 0;

    logic [7:0] tx_q[$];
    int         tx_cyc_q[$];
    logic       pend       = 1'b0;
    logic       resp_block = 1'b0;
    int         delay      = 0;
    logic [7:0] held       = 8'h00;

    logic [7:0] m_gate_in = 8'h00;
    int         m_err     = 0;

    logic [7:0] r_opc, r_opd, r_chk, r_noise;
    int         kind, n;

    assign gate_out = gate_mode ? gate_fixed : ~gate_in;

    uart_cmd_parser #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .RX_DONE   (rx_done),
        .RX_BUFFER (rx_buffer),
        .TX_DONE   (tx_done),
        .GATE_OUT  (gate_out),
        .RX_TRIGGER(rx_trigger),
        .TX_TRIGGER(tx_trigger),
        .TX_BUFFER (tx_buffer),
        .GATE_IN   (gate_in),
        .BUSY      (busy),
        .ERR_COUNT (err_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmitter model: logs every triggered byte and answers with TX_DONE later.
    always @(negedge clk) begin
        if (rst) begin
            pend    = 1'b0;
            tx_done = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (pend && !resp_block) begin
                if (delay == 0) begin
                    check_value("tx_hold", 32'(tx_buffer), 32'(held));
                    tx_done = 1'b1;
                    pend    = 1'b0;
                end else begin
                    delay = delay - 1;
                end
            end
            if (tx_trigger) begin
                tx_q.push_back(tx_buffer);
                tx_cyc_q.push_back(cyc);
                held  = tx_buffer;
                pend  = 1'b1;
                delay = $urandom_range(0, 5);
            end
        end
    end

    function automatic int pick_gap(input int gap);
        return (gap < 0) ? int'($urandom_range(0, T - 2)) : gap;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_done     = 1'b1;
        rx_buffer   = b;
        last_rx_cyc = cyc;
        @(negedge clk);
        rx_done   = 1'b0;
        rx_buffer = 8'($urandom);
        repeat (gap) @(negedge clk);
    endtask

    // Waits for a full reply, spraying SYNC bytes that must be ignored once replying.
    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while ((tx_q.size() < 2 || busy) && k < budget) begin
            @(negedge clk);
            k++;
            rx_done   = busy && (tx_q.size() > 0) && ($urandom_range(0, 3) == 0);
            rx_buffer = 8'hA5;
        end
        rx_done = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] opc, input logic [7:0] opd,
                             input logic [7:0] chk, input int gap);
        logic [7:0] exp0, exp1;
        int lat, chk_cyc;
        if (((opc ^ opd) != chk) || !(opc == 8'h01 || opc == 8'h02)) begin
            exp0  = 8'h15;
            exp1  = opc;
            lat   = 2;
            m_err = (m_err < 255) ? m_err + 1 : 255;
        end else if (opc == 8'h01) begin
            m_gate_in = opd;
            exp0 = 8'h06;
            exp1 = gate_mode ? gate_fixed : ~opd;
            lat  = S + 2;
        end else begin
            exp0 = 8'h06;
            exp1 = gate_mode ? gate_fixed : ~m_gate_in;
            lat  = 2;
        end
        tx_q.delete();
        tx_cyc_q.delete();
        send_byte(8'hA5, pick_gap(gap));
        send_byte(opc, pick_gap(gap));
        send_byte(opd, pick_gap(gap));
        chk_cyc = cyc;
        send_byte(chk, 0);
        wait_idle(S + 100);
        check_value("reply_len", 32'(tx_q.size()), 32'd2);
        if (tx_q.size() >= 2) begin
            check_value("reply_byte0", 32'(tx_q[0]), 32'(exp0));
            check_value("reply_byte1", 32'(tx_q[1]), 32'(exp1));
            check_value("latency", 32'(tx_cyc_q[0] - chk_cyc), 32'(lat));
        end
        check_value("busy_end", 32'(busy), 32'd0);
        check_value("gate_in", 32'(gate_in), 32'(m_gate_in));
        check_value("err_count", 32'(err_count), 32'(m_err));
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_value("rst_tx_trigger", 32'(tx_trigger), 32'd0);
        check_value("rst_tx_buffer", 32'(tx_buffer), 32'd0);
        check_value("rst_gate_in", 32'(gate_in), 32'd0);
        check_value("rst_err_count", 32'(err_count), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_rx_trigger", 32'(rx_trigger), 32'd0);
        rst = 1'b0;
        #1;
        check_value("rx_trig_before_edge", 32'(rx_trigger), 32'd0);
        @(negedge clk);
        check_value("rx_trig_after_edge", 32'(rx_trigger), 32'd1);

        // Directed frames: APPLY with inverting gate, READ, bad checksum.
        gate_mode = 1'b0;
        run_frame(8'h01, 8'h3C, 8'h3D, -1);
        gate_mode  = 1'b1;
        gate_fixed = 8'h5A;
        run_frame(8'h02, 8'h00, 8'h02, -1);
        run_frame(8'h01, 8'h3C, 8'h00, -1);
        // Inter-byte gap one short of the timeout: byte must still be accepted.
        run_frame(8'h02, 8'h10, 8'h12, T - 1);

        // Timeout mid-frame.
        tx_q.delete();
        send_byte(8'h11, 2);
        send_byte(8'hA5, 3);
        send_byte(8'h01, T - 2);
        check_value("timeout_pending", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        check_value("timeout_busy", 32'(busy), 32'd0);
        check_value("timeout_no_tx", 32'(tx_q.size()), 32'd0);
        check_value("timeout_err", 32'(err_count), 32'(m_err));
        gate_fixed = 8'($urandom);
        run_frame(8'h02, 8'h77, 8'h75, -1);

        // Randomized frames.
        for (int i = 0; i < 60; i++) begin
            kind       = $urandom_range(0, 3);
            gate_mode  = 1'($urandom_range(0, 1));
            gate_fixed = 8'($urandom);
            r_opd      = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                r_noise = 8'($urandom);
                if (r_noise == 8'hA5) r_noise = 8'h5A;
                send_byte(r_noise, pick_gap(-1));
            end
            case (kind)
                0: begin r_opc = 8'h01; r_chk = r_opc ^ r_opd; end
                1: begin r_opc = 8'h02; r_chk = r_opc ^ r_opd; end
                2: begin
                    r_opc = 8'($urandom_range(1, 2));
                    r_chk = r_opc ^ r_opd ^ 8'($urandom_range(1, 255));
                end
                default: begin
                    r_opc = 8'($urandom);
                    if (r_opc == 8'h01 || r_opc == 8'h02) r_opc = 8'h03;
                    r_chk = r_opc ^ r_opd;
                end
            endcase
            run_frame(r_opc, r_opd, r_chk, -1);
        end

        // Reset while waiting for the first byte to finish.
        resp_block = 1'b1;
        gate_mode  = 1'b0;
        tx_q.delete();
        send_byte(8'hA5, 0);
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        n = 0;
        while (tx_q.size() == 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_value("rst_reach_send", 32'(tx_q.size()), 32'd1);
        @(negedge clk);
        check_value("rst_in_wait0", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check_value("rst_async_trigger", 32'(tx_trigger), 32'd0);
        check_value("rst_async_busy", 32'(busy), 32'd0);
        check_value("rst_async_rx_trig", 32'(rx_trigger), 32'd0);
        check_value("rst_async_tx_buf", 32'(tx_buffer), 32'd0);
        check_value("rst_async_gate_in", 32'(gate_in), 32'd0);
        check_value("rst_async_err", 32'(err_count), 32'd0);
        @(negedge clk);
        tx_q.delete();
        rst        = 1'b0;
        resp_block = 1'b0;
        m_gate_in  = 8'h00;
        m_err      = 0;
        repeat (20) @(negedge clk);
        check_value("rst_no_tx", 32'(tx_q.size()), 32'd0);
        check_value("rst_idle_busy", 32'(busy), 32'd0);
        check_value("rst_rx_trig_back", 32'(rx_trigger), 32'd1);

        // NAK flood: counter must saturate at 255.
        for (int i = 0; i < 256; i++) begin
            r_opd = 8'($urandom);
            if (i % 2 == 0) begin
                r_opc = 8'h07;
                r_chk = r_opc ^ r_opd;
            end else begin
                r_opc = 8'h01;
                r_chk = ~(r_opc ^ r_opd);
            end
            run_frame(r_opc, r_opd, r_chk, 0);
        end
        check_value("err_saturated", 32'(err_count), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
